aes128_key_expand: RTL and testbench
====================================

AES128_KEY_EXPAND -- requirements
Module: aes128_key_expand

Interface
REQ-001 SHALL have parameter: NUM_ROUNDS, 10, number of round keys after round 0; only 10 supported.
REQ-002 SHALL have port: clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: key_in  input  128  cipher key, sampled when key_load=1.
REQ-005 SHALL have port: key_load  input  1  one-cycle start pulse; captures key_in.
REQ-006 SHALL have port: next_req  input  1  request the next round key; honoured only when key_valid=1.
REQ-007 SHALL have port: round_key  output  128  current round key; drives the add-round-key stage directly.
REQ-008 SHALL have port: round_num  output  4  index 0..10 of round_key.
REQ-009 SHALL have port: key_valid  output  1  round_key/round_num stable and usable.
REQ-010 SHALL have port: last_round  output  1  key_valid=1 and round_num=10.

Function
REQ-011 SHALL implement states IDLE, READY, CALC.
REQ-012 SHALL move from any state to READY one cycle after key_load=1, with round_key=key_in, round_num=0, key_valid=1.
REQ-013 SHALL move from READY to CALC on next_req=1 when round_num<10, deasserting key_valid in the next cycle.
REQ-014 SHALL ignore next_req in READY when round_num=10; last_round stays 1 and round_key is held.
REQ-015 SHALL compute w4=w0^SubWord(RotWord(w3))^Rcon, w5=w4^w1, w6=w5^w2, w7=w6^w3; w0 is bits [127:96].
REQ-016 SHALL use Rcon for round numbers 1..10 as 01,02,04,08,10,20,40,80,1B,36, placed in the MSB byte.
REQ-017 SHALL return from CALC to READY with round_num incremented and key_valid=1 when the new key is registered.
REQ-018 SHALL hold round_key and round_num unchanged whenever key_valid=1 and no request is accepted.
REQ-019 SHALL give key_load priority over next_req when both are asserted in the same cycle.
REQ-020 SHALL abort an in-progress CALC on key_load and restart at round 0.
REQ-021 SHALL ignore next_req while in IDLE or CALC; requests are not queued.

Reset
REQ-022 SHALL, while reset=0, force state IDLE, round_key=0, round_num=0, key_valid=0, last_round=0, and clear the byte counter.
REQ-023 SHALL act on reset assertion immediately without waiting for a clock edge.
REQ-024 SHALL stay in IDLE after reset deassertion until key_load=1.

Configuration
REQ-025 SHALL use the macro KEY_SCHED_SBOX_SERIAL_EN to select S-box sharing.
REQ-026 SHALL, without the macro, instantiate four S-boxes and spend exactly 1 CALC cycle, so key_valid returns 2 cycles after the accepted next_req.
REQ-027 SHALL, with the macro, instantiate one S-box, substitute bytes w3[23:16], [15:8], [7:0], [31:24] over 4 CALC cycles with a 2-bit counter, and return key_valid 5 cycles after the accepted next_req.
REQ-028 SHALL produce bit-identical round keys in both configurations.

Structure
REQ-029 SHALL place the Rcon table, state encoding, and AES_KEY_W=128 / AES_ROUNDS=10 constants in the shared aes_pkg package.
REQ-030 SHALL put byte substitution in sub-module aes_sbox (8-bit in, 8-bit out, combinational), which the SubBytes stage also reuses.
REQ-031 SHALL keep all next-state and key arithmetic combinational, registering only in the state/key registers.

Verification
REQ-032 SHALL check that key_load with key_in=2b7e151628aed2a6abf7158809cf4f3c gives round 0 = key_in and round 1 = a0fafe1788542cb123a339392a6c7605.
REQ-033 SHALL check that 10 back-to-back requests on the same key end with round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6 and last_round=1.
REQ-034 SHALL check that an 11th next_req at round 10 leaves round_key, round_num=10 and key_valid=1 unchanged.
REQ-035 SHALL check that key_load issued mid-CALC (round 3) with key 000102..0f restarts at round_num=0, and that round 1 = d6aa74fdd2af72fadaa678f1d6ab76fe.
REQ-036 SHALL check that asserting reset in the middle of a CALC cycle zeroes all outputs asynchronously, and that the block ignores next_req until a new key_load.
REQ-037 SHALL check that, in both macro settings, the cycle count from next_req to key_valid is 2 (parallel) or 5 (serial), with identical key sequences.

Source files
------------

// File: rtl/aes_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// aes_pkg -- shared AES-128 key-schedule constants, state encoding and helpers
// Revision: 1.0
// ---------------------------------------------------------------------------
package aes_pkg;

  localparam int unsigned AES_KEY_W  = 128;
  localparam int unsigned AES_ROUNDS = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READY = 2'd1,
    CALC  = 2'd2
  } ks_state_e;

  // Round constant for rounds 1..10, MSB byte of the word; other indices give 0.
  function automatic logic [7:0] aes_rcon(input logic [3:0] rnd);
    logic [7:0] rc;
    case (rnd)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  // One key-schedule step; sub_rot is SubWord(RotWord(w3)) of the current key.
  function automatic logic [AES_KEY_W-1:0] aes_next_round_key(
    input logic [AES_KEY_W-1:0] key,
    input logic [31:0]          sub_rot,
    input logic [7:0]           rcon
  );
    logic [31:0] w4;
    logic [31:0] w5;
    logic [31:0] w6;
    logic [31:0] w7;
    w4 = key[127:96] ^ sub_rot ^ {rcon, 24'h000000};
    w5 = w4 ^ key[95:64];
    w6 = w5 ^ key[63:32];
    w7 = w6 ^ key[31:0];
    return {w4, w5, w6, w7};
  endfunction

endpackage
`default_nettype wire

// File: rtl/aes_sbox.sv
`default_nettype none
// ---------------------------------------------------------------------------
// aes_sbox -- combinational AES forward S-box, one byte in, one byte out
// Revision: 1.0
// ---------------------------------------------------------------------------
module aes_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  // Row-major table, entry 0x00 in the top byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [10:0] w_base;

  // Entry i sits at bit 8*(255-i); ~i yields 255-i without a subtractor.
  assign w_base   = {~in_byte, 3'b000};
  assign out_byte = SBOX_TABLE[w_base +: 8];

endmodule
`default_nettype wire

// File: rtl/aes128_key_expand.sv
`default_nettype none
// ---------------------------------------------------------------------------
// aes128_key_expand -- on-demand AES-128 round-key generator (rounds 0..10)
// Define KEY_SCHED_SBOX_SERIAL_EN to share one S-box over 4 CALC cycles.
// Revision: 1.0
// ---------------------------------------------------------------------------
module aes128_key_expand
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = AES_ROUNDS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [AES_KEY_W-1:0] key_in,
  input  logic                 key_load,
  input  logic                 next_req,
  output logic [AES_KEY_W-1:0] round_key,
  output logic [3:0]           round_num,
  output logic                 key_valid,
  output logic                 last_round
);

  localparam logic [3:0] C_LAST_RND = 4'(NUM_ROUNDS);

  ks_state_e            state_q;
  ks_state_e            state_d;
  logic [AES_KEY_W-1:0] key_q;
  logic [AES_KEY_W-1:0] key_d;
  logic [3:0]           rnd_q;
  logic [3:0]           rnd_d;
  logic [3:0]           rnd_inc;
  logic [31:0]          sub_rot;
  logic [AES_KEY_W-1:0] next_key;

`ifdef KEY_SCHED_SBOX_SERIAL_EN
  logic [1:0]  cnt_q;
  logic [1:0]  cnt_d;
  logic [23:0] sub_q;
  logic [23:0] sub_d;
  logic [7:0]  sbox_in;
  logic [7:0]  sbox_out;

  // Visit w3 bytes in RotWord order so the shifted result is already rotated.
  always_comb begin
    sbox_in = key_q[23:16];
    case (cnt_q)
      2'd0: sbox_in = key_q[23:16];
      2'd1: sbox_in = key_q[15:8];
      2'd2: sbox_in = key_q[7:0];
      2'd3: sbox_in = key_q[31:24];
      default: sbox_in = key_q[23:16];
    endcase
  end

  aes_sbox u_sbox (
    .in_byte  (sbox_in),
    .out_byte (sbox_out)
  );

  assign sub_rot = {sub_q, sbox_out};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= 2'd0;
      sub_q <= 24'h000000;
    end else begin
      cnt_q <= cnt_d;
      sub_q <= sub_d;
    end
  end
`else
  logic [31:0] rot_word;

  assign rot_word = {key_q[23:0], key_q[31:24]};

  generate
    for (genvar i = 0; i < 4; i++) begin : g_sbox
      aes_sbox u_sbox (
        .in_byte  (rot_word[8*i +: 8]),
        .out_byte (sub_rot[8*i +: 8])
      );
    end
  endgenerate
`endif

  assign rnd_inc  = rnd_q + 4'd1;
  assign next_key = aes_next_round_key(key_q, sub_rot, aes_rcon(rnd_inc));

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    rnd_d   = rnd_q;
`ifdef KEY_SCHED_SBOX_SERIAL_EN
    cnt_d   = cnt_q;
    sub_d   = sub_q;
`endif
    if (key_load) begin
      state_d = READY;
      key_d   = key_in;
      rnd_d   = 4'd0;
`ifdef KEY_SCHED_SBOX_SERIAL_EN
      cnt_d   = 2'd0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
        end
        READY: begin
          if (next_req && (rnd_q < C_LAST_RND)) begin
            state_d = CALC;
`ifdef KEY_SCHED_SBOX_SERIAL_EN
            cnt_d   = 2'd0;
`endif
          end
        end
        CALC: begin
`ifdef KEY_SCHED_SBOX_SERIAL_EN
          cnt_d = cnt_q + 2'd1;
          sub_d = {sub_q[15:0], sbox_out};
          if (cnt_q == 2'd3) begin
            key_d   = next_key;
            rnd_d   = rnd_inc;
            state_d = READY;
          end
`else
          key_d   = next_key;
          rnd_d   = rnd_inc;
          state_d = READY;
`endif
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      key_q   <= '0;
      rnd_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      rnd_q   <= rnd_d;
    end
  end

  assign round_key  = key_q;
  assign round_num  = rnd_q;
  assign key_valid  = (state_q == READY);
  assign last_round = key_valid && (rnd_q == C_LAST_RND);

endmodule
`default_nettype wire

// File: tb/tb_aes128_key_expand.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_aes128_key_expand -- self-checking bench against a GF(2^8)-based model
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_aes128_key_expand;

`ifdef KEY_SCHED_SBOX_SERIAL_EN
  localparam int EXP_LAT = 5;
`else
  localparam int EXP_LAT = 2;
`endif

  logic         clk;
  logic         reset;
  logic [127:0] key_in;
  logic         key_load;
  logic         next_req;
  logic [127:0] round_key;
  logic [3:0]   round_num;
  logic         key_valid;
  logic         last_round;

  int checks;
  int errors;
  logic [127:0] ref_rk [0:10];

  aes128_key_expand #(.NUM_ROUNDS(10)) dut (
    .clk        (clk),
    .reset      (reset),
    .key_in     (key_in),
    .key_load   (key_load),
    .next_req   (next_req),
    .round_key  (round_key),
    .round_num  (round_num),
    .key_valid  (key_valid),
    .last_round (last_round)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model: S-box from GF(2^8) inverse + affine map
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [15:0] d;
    d = {v, v} << n;
    return d[15:8];
  endfunction

  function automatic logic [7:0] model_sbox(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h01;
    if (x == 8'h00) inv = 8'h00;
    else for (int i = 0; i < 254; i++) inv = gmul(inv, x);
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  task automatic model_expand(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {model_sbox(t[23:16]), model_sbox(t[15:8]), model_sbox(t[7:0]),
             model_sbox(t[31:24])} ^ {rc, 24'h000000};
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) ref_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // ---------------- helpers
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_key(input logic [127:0] k);
    key_in   = k;
    key_load = 1'b1;
    tick();
    key_load = 1'b0;
  endtask

  // Issue one request and wait (bounded) for the new key.
  task automatic do_req(input string tag, input int exp_rnd);
    int lat;
    next_req = 1'b1;
    tick();
    next_req = 1'b0;
    lat = 1;
    while (!key_valid && lat < 40) begin
      tick();
      lat++;
    end
    check({tag, "_lat"}, 128'(lat), 128'(EXP_LAT));
    check({tag, "_key"}, round_key, ref_rk[exp_rnd]);
    check({tag, "_num"}, 128'(round_num), 128'(exp_rnd));
    check({tag, "_last"}, 128'(last_round), 128'(exp_rnd == 10));
  endtask

  task automatic full_run(input string tag, input logic [127:0] k);
    model_expand(k);
    load_key(k);
    check({tag, "_r0"}, round_key, ref_rk[0]);
    check({tag, "_r0_valid"}, 128'(key_valid), 128'd1);
    for (int r = 1; r <= 10; r++) do_req(tag, r);
  endtask

  logic [127:0] held;
  logic [127:0] rkey;

  initial begin
    checks   = 0;
    errors   = 0;
    reset    = 1'b0;
    key_in   = '0;
    key_load = 1'b0;
    next_req = 1'b0;

    // Reset state
    tick();
    check("rst_key", round_key, 128'h0);
    check("rst_num", 128'(round_num), 128'd0);
    check("rst_valid", 128'(key_valid), 128'd0);
    check("rst_last", 128'(last_round), 128'd0);
    reset = 1'b1;

    // Requests in IDLE are ignored
    next_req = 1'b1;
    tick();
    tick();
    next_req = 1'b0;
    check("idle_ignore_valid", 128'(key_valid), 128'd0);
    check("idle_ignore_num", 128'(round_num), 128'd0);

    // FIPS-197 key: known round 1 and round 10
    model_expand(128'h2b7e151628aed2a6abf7158809cf4f3c);
    load_key(128'h2b7e151628aed2a6abf7158809cf4f3c);
    check("fips_r0", round_key, 128'h2b7e151628aed2a6abf7158809cf4f3c);
    check("fips_r0_num", 128'(round_num), 128'd0);
    check("fips_r0_valid", 128'(key_valid), 128'd1);
    do_req("fips", 1);
    check("fips_r1", round_key, 128'ha0fafe1788542cb123a339392a6c7605);
    held = round_key;
    tick(); tick(); tick();
    check("hold_key", round_key, held);
    check("hold_num", 128'(round_num), 128'd1);
    for (int r = 2; r <= 10; r++) do_req("fips", r);
    check("fips_r10", round_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    check("fips_last", 128'(last_round), 128'd1);

    // Request at round 10 is ignored
    next_req = 1'b1;
    tick();
    next_req = 1'b0;
    tick(); tick(); tick(); tick(); tick();
    check("r11_key", round_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    check("r11_num", 128'(round_num), 128'd10);
    check("r11_valid", 128'(key_valid), 128'd1);
    check("r11_last", 128'(last_round), 128'd1);

    // key_load during the round-3 CALC restarts at round 0
    load_key(128'h2b7e151628aed2a6abf7158809cf4f3c);
    model_expand(128'h2b7e151628aed2a6abf7158809cf4f3c);
    do_req("pre", 1);
    do_req("pre", 2);
    next_req = 1'b1;
    tick();
    next_req = 1'b0;
    check("midcalc_busy", 128'(key_valid), 128'd0);
    model_expand(128'h000102030405060708090a0b0c0d0e0f);
    load_key(128'h000102030405060708090a0b0c0d0e0f);
    check("abort_num", 128'(round_num), 128'd0);
    check("abort_key", round_key, 128'h000102030405060708090a0b0c0d0e0f);
    check("abort_valid", 128'(key_valid), 128'd1);
    do_req("abort", 1);
    check("abort_r1", round_key, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe);

    // Randomised keys against the model
    for (int n = 0; n < 3; n++) begin
      rkey = {$urandom, $urandom, $urandom, $urandom};
      full_run($sformatf("rand%0d", n), rkey);
    end

    // key_load wins over a simultaneous next_req
    rkey = {$urandom, $urandom, $urandom, $urandom};
    model_expand(rkey);
    key_in   = rkey;
    key_load = 1'b1;
    next_req = 1'b1;
    tick();
    key_load = 1'b0;
    next_req = 1'b0;
    check("prio_num", 128'(round_num), 128'd0);
    check("prio_key", round_key, rkey);
    do_req("prio", 1);
    do_req("prio", 2);

    // Asynchronous reset in the middle of a CALC cycle
    next_req = 1'b1;
    tick();
    next_req = 1'b0;
    #3;
    reset = 1'b0;
    #1;
    check("areset_key", round_key, 128'h0);
    check("areset_num", 128'(round_num), 128'd0);
    check("areset_valid", 128'(key_valid), 128'd0);
    check("areset_last", 128'(last_round), 128'd0);
    tick();
    reset = 1'b1;
    next_req = 1'b1;
    tick(); tick(); tick(); tick(); tick(); tick();
    next_req = 1'b0;
    check("post_rst_valid", 128'(key_valid), 128'd0);
    check("post_rst_num", 128'(round_num), 128'd0);
    full_run("post_rst", {$urandom, $urandom, $urandom, $urandom});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
